// File: rtl/sentry_control_icache_sched_pkg.sv
// sentry_control_icache_sched_pkg: shared widths, defaults and the buffered request bundle type
package sentry_control_icache_sched_pkg;
  localparam int SCHED_SW = 4;
  localparam int SCHED_NP = 2;
  localparam int SCHED_DEPTH = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] data_t;
  typedef struct packed {
    logic [SCHED_SW-1:0] mask;
    addr_t [SCHED_SW-1:0] addr;
    data_t [SCHED_SW-1:0] result;
  } icache_req_bundle_s;
endpackage

// File: rtl/sentry_control_icache_sched_lane_pick.sv
// sentry_control_lane_pick: picks the first NP valid lanes at or above lane_ptr, in ascending order
module sentry_control_lane_pick #(
  parameter int SW = 4,
  parameter int NP = 2,
  parameter int LW = 2
) (
  input  logic [SW-1:0]         mask,
  input  logic [LW-1:0]         lane_ptr,
  output logic [NP-1:0][LW-1:0] sel_idx,
  output logic [NP-1:0]         sel_valid,
  output logic [LW-1:0]         next_ptr,
  output logic                  last_done
);
  int k;
  always_comb begin
    sel_idx = '0;
    sel_valid = '0;
    next_ptr = '0;
    last_done = 1'b1;
    k = 0;
    for (int i = 0; i < SW; i++) begin
      if (mask[i] && i >= int'(lane_ptr)) begin
        for (int p = 0; p < NP; p++) begin
          if (k == p) begin
            sel_idx[p] = LW'(i);
            sel_valid[p] = 1'b1;
            next_ptr = LW'(i + 1);
          end
        end
        if (k >= NP) last_done = 1'b0;
        k = k + 1;
      end
    end
  end
endmodule

// File: rtl/sentry_control_icache_sched.sv
// sentry_control_icache_sched: bundle FIFO that drains lanes onto NUM_PORTS icache ports in program order
module sentry_control_icache_sched
  import sentry_control_icache_sched_pkg::*;
#(
  parameter int NUM_PORTS = SCHED_NP,
  parameter int DEPTH = SCHED_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [SCHED_SW-1:0]                 in_req_valid,
  input  logic [SCHED_SW-1:0][AW-1:0]         in_req_address,
  input  logic [SCHED_SW-1:0][DW-1:0]         in_req_inst_result,
  output logic                                icache_req_almost_full,
  input  logic                                icache_port_ready,
  output logic [NUM_PORTS-1:0]                icache_port_valid,
  output logic [NUM_PORTS-1:0][AW-1:0]        icache_port_address,
  output logic [NUM_PORTS-1:0][DW-1:0]        icache_port_result,
  output logic                                overflow_err,
  output logic [31:0]                         issued_count
);
  localparam int SW = SCHED_SW;
  localparam int LW = SW > 1 ? $clog2(SW) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  icache_req_bundle_s mem_q [DEPTH];
  icache_req_bundle_s head;
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic [LW-1:0] lane_q, next_ptr;
  logic [NUM_PORTS-1:0][LW-1:0] sel_idx;
  logic [NUM_PORTS-1:0] sel_valid;
  logic [SW-1:0] head_mask;
  logic last_done, fire, push, pop;
  assign head = mem_q[rd_q];
  assign head_mask = count_q != '0 ? head.mask : '0;
  assign fire = icache_port_ready && |sel_valid;
  assign pop = fire && last_done;
  // a full FIFO still accepts when the head leaves on the same edge
  assign push = |in_req_valid && (count_q < CW'(DEPTH) || pop);
  assign icache_req_almost_full = count_q >= CW'(DEPTH - 1);
  assign icache_port_valid = sel_valid;
  sentry_control_lane_pick #(.SW(SW), .NP(NUM_PORTS), .LW(LW)) u_pick (
    .mask(head_mask),
    .lane_ptr(lane_q),
    .sel_idx(sel_idx),
    .sel_valid(sel_valid),
    .next_ptr(next_ptr),
    .last_done(last_done)
  );
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign icache_port_address[g] = head.addr[sel_idx[g]];
    assign icache_port_result[g] = head.result[sel_idx[g]];
  end
  always_ff @(posedge clk) begin
    if (!rst && !flush && push)
      mem_q[wr_q] <= '{mask: in_req_valid, addr: in_req_address, result: in_req_inst_result};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      lane_q <= '0;
      overflow_err <= 1'b0;
      issued_count <= '0;
    end else begin
      if (|in_req_valid && !push) overflow_err <= 1'b1;
      if (flush) begin
        wr_q <= '0;
        rd_q <= '0;
        count_q <= '0;
        lane_q <= '0;
      end else begin
        if (push) wr_q <= wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1;
        if (pop) rd_q <= rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1;
        count_q <= count_q + CW'(push) - CW'(pop);
        if (fire) begin
          issued_count <= issued_count + 32'($countones(sel_valid));
          lane_q <= last_done ? '0 : next_ptr;
        end
      end
    end
  end
endmodule
